// File: rtl/vga_pkg.sv
// vga_pkg: capture FSM state type and default 640x480@60 VGA timing shared by the VGA blocks
package vga_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} cap_state_t;
    localparam int DEF_H_TOTAL = 800;
    localparam int DEF_V_TOTAL = 525;
    localparam int DEF_X0 = 144;
    localparam int DEF_Y0 = 35;
    localparam int DEF_IMG_W = 100;
    localparam int DEF_IMG_H = 100;
endpackage

// File: rtl/sync_tracker.sv
// sync_tracker: sync edge detection and saturating beam position counters
module sync_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Hsync,
    input  logic       Vsync,
    output logic       hRise,
    output logic       vRise,
    output logic [9:0] hCount,
    output logic [9:0] vCount
);
    logic hsync_q, vsync_q;

    assign hRise = Hsync & ~hsync_q;
    assign vRise = Vsync & ~vsync_q;

    // vRise wins over the line increment so coincident edges land on line 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            hCount  <= '0;
            vCount  <= '0;
        end else begin
            hsync_q <= Hsync;
            vsync_q <= Vsync;
            hCount  <= hRise ? '0 : (&hCount) ? hCount : hCount + 10'd1;
            vCount  <= vRise ? '0 : (hRise && !(&vCount)) ? vCount + 10'd1 : vCount;
        end
    end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: on arm, writes one IMG_W x IMG_H window of the next full frame to a frame buffer
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int X0 = DEF_X0,
    parameter int Y0 = DEF_Y0,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic        clk_25Mhz,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  pixelIn,
    output logic [15:0] wrAddress,
    output logic [7:0]  wrData,
    output logic        wrEnable,
    output logic        busy,
    output logic        frameDone,
    output logic        syncError
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + IMG_W - 1);
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + IMG_H - 1);
    localparam logic [15:0] W16 = 16'(IMG_W);

    cap_state_t state, next;
    logic hRise, vRise, h_seen, v_seen, in_win, sample, last, accept;
    logic [9:0] hCount, vCount;
    logic [15:0] addr;

    sync_tracker u_sync (
        .clk(clk_25Mhz),
        .rst_n(rst_n),
        .Hsync(Hsync),
        .Vsync(Vsync),
        .hRise(hRise),
        .vRise(vRise),
        .hCount(hCount),
        .vCount(vCount)
    );

    assign in_win = hCount >= X_LO && hCount <= X_HI && vCount >= Y_LO && vCount <= Y_HI;
    assign sample = state == CAPTURE && in_win && !vRise;
    assign last   = sample && hCount == X_HI && vCount == Y_HI;
    assign accept = state == IDLE && arm;
    assign addr   = {6'd0, vCount - Y_LO} * W16 + {6'd0, hCount - X_LO};
    assign busy   = state == WAIT_FRAME || state == CAPTURE;

    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:       next = arm ? WAIT_FRAME : IDLE;
            WAIT_FRAME: next = vRise ? CAPTURE : WAIT_FRAME;
            CAPTURE:    next = vRise ? IDLE : last ? DONE : CAPTURE;
            default:    next = IDLE;
        endcase
    end

    // The first sync edge after reset or an accepted arm only establishes alignment
    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            wrAddress <= '0;
            wrData    <= '0;
            wrEnable  <= 1'b0;
            frameDone <= 1'b0;
            syncError <= 1'b0;
            h_seen    <= 1'b0;
            v_seen    <= 1'b0;
        end else begin
            wrEnable  <= sample;
            frameDone <= last;
            if (sample) begin
                wrAddress <= addr;
                wrData    <= pixelIn;
            end
            h_seen    <= !accept && (h_seen || hRise);
            v_seen    <= !accept && (v_seen || vRise);
            syncError <= !accept && (syncError || (hRise && h_seen && hCount != H_LAST) ||
                         (vRise && v_seen && vCount != V_LAST) || (state == CAPTURE && vRise));
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench for vga_capture on a scaled-down raster to keep runs short
module tb_vga_capture;
    localparam int HT = 64, VT = 24, X0 = 20, Y0 = 5, W = 32, H = 12, HS = 8;
    localparam int N = W * H, FRAME = HT * VT, CUT_LINE = Y0 + 5;

    logic clk_25Mhz = 1'b0, rst_n = 1'b1, arm = 1'b0, Hsync = 1'b0, Vsync = 1'b0;
    logic [7:0] pixelIn = '0;
    logic [15:0] wrAddress;
    logic [7:0] wrData;
    logic wrEnable, busy, frameDone, syncError;

    int n_checks = 0, n_fail = 0;
    int hc = 0, vc = 3, last_h = HT - 1;
    int short_req = 0, short_done = 0, cut_req = 0, cut_done = 0;
    logic cut_now = 1'b0, pix_line = 1'b0;
    logic [23:0] exp_q[$];

    vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .X0(X0), .Y0(Y0), .IMG_W(W), .IMG_H(H)) dut (
        .clk_25Mhz(clk_25Mhz),
        .rst_n(rst_n),
        .arm(arm),
        .Hsync(Hsync),
        .Vsync(Vsync),
        .pixelIn(pixelIn),
        .wrAddress(wrAddress),
        .wrData(wrData),
        .wrEnable(wrEnable),
        .busy(busy),
        .frameDone(frameDone),
        .syncError(syncError)
    );

    always #5 clk_25Mhz = ~clk_25Mhz;

    // Raster source: hc/vc equal the DUT's hCount/vCount once aligned; sync rises on a line's last clock
    initial begin
        forever begin
            @(negedge clk_25Mhz);
            if (hc == last_h) begin
                hc = 0;
                if (short_req != short_done) short_done++;
                if (cut_now) cut_done++;
                vc = (vc == VT - 1 || cut_now) ? 0 : vc + 1;
            end else hc++;
            last_h  = (short_req != short_done) ? HT - 2 : HT - 1;
            cut_now = cut_req != cut_done && vc == CUT_LINE;
            Hsync   = hc == last_h || hc < HS;
            Vsync   = (hc == last_h && (vc == VT - 1 || cut_now)) || vc < 2;
            pixelIn = pix_line ? 8'(vc) : 8'(hc);
        end
    end

    task automatic tick;
        @(negedge clk_25Mhz);
        #1;
    endtask

    task automatic test_reset;
        int stray = 0;
        #3 rst_n = 1'b0;
        tick;
        n_checks++;
        if ({wrAddress, wrData, wrEnable, busy, frameDone, syncError} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d data=%0d we=%b busy=%b done=%b err=%b, expected all 0",
                     wrAddress, wrData, wrEnable, busy, frameDone, syncError);
        end
        for (int t = 0; t < 2 * FRAME && !(hc == HS + 2 && vc >= 2); t++) tick;
        rst_n = 1'b1;
        repeat (2 * FRAME) begin
            tick;
            if (wrEnable) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL idle_writes: got %0d expected 0", stray); end
        n_checks++;
        if (syncError !== 1'b0) begin n_fail++; $display("FAIL nominal_sync: got %b expected 0", syncError); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_frame;
        int writes = 0, dones = 0;
        logic [23:0] e;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({16'(i), 8'(X0 + i % W)});
        for (int t = 0; t < 2 * FRAME && !(vc == Y0 + 3 && hc == 0); t++) tick;
        arm = 1'b1;
        tick;
        arm = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b expected 1", busy); end
        repeat (2 * FRAME + 4 * HT) begin
            tick;
            arm = 1'b0;
            if (wrEnable) begin
                writes++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL full_extra: got write addr=%0d data=%0d expected none", wrAddress, wrData);
                end else begin
                    e = exp_q.pop_front();
                    if ({wrAddress, wrData} !== e) begin
                        n_fail++;
                        $display("FAIL full_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 wrAddress, wrData, e[23:8], e[7:0]);
                    end
                end
                if (writes == 50) arm = 1'b1;
            end
            if (frameDone) begin
                dones++;
                n_checks++;
                if ({wrEnable, busy, wrAddress} !== {2'b10, 16'(N - 1)}) begin
                    n_fail++;
                    $display("FAIL full_done: got we=%b busy=%b addr=%0d expected we=1 busy=0 addr=%0d",
                             wrEnable, busy, wrAddress, N - 1);
                end
            end
        end
        n_checks++;
        if (writes !== N) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", writes, N); end
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL full_dones: got %0d expected 1", dones); end
        n_checks++;
        if ({wrAddress, wrData} !== {16'(N - 1), 8'(X0 + W - 1)}) begin
            n_fail++;
            $display("FAIL full_hold: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     wrAddress, wrData, N - 1, X0 + W - 1);
        end
        n_checks++;
        if (syncError !== 1'b0) begin n_fail++; $display("FAIL full_sync: got %b expected 0", syncError); end
    endtask

    task automatic test_short_line;
        int writes = 0, dones = 0;
        for (int t = 0; t < 2 * HT && hc != 10; t++) tick;
        n_checks++;
        if (syncError !== 1'b0) begin n_fail++; $display("FAIL short_pre: got %b expected 0", syncError); end
        short_req++;
        for (int t = 0; t < 4 * HT && short_done != short_req; t++) tick;
        tick;
        tick;
        n_checks++;
        if (syncError !== 1'b1) begin n_fail++; $display("FAIL short_set: got %b expected 1", syncError); end
        repeat (FRAME) tick;
        n_checks++;
        if (syncError !== 1'b1) begin n_fail++; $display("FAIL short_sticky: got %b expected 1", syncError); end
        arm = 1'b1;
        tick;
        arm = 1'b0;
        n_checks++;
        if (syncError !== 1'b0) begin n_fail++; $display("FAIL short_clear: got %b expected 0", syncError); end
        repeat (2 * FRAME + 4 * HT) begin
            tick;
            if (wrEnable) writes++;
            if (frameDone) dones++;
        end
        n_checks++;
        if ({writes, dones} !== {N, 32'd1}) begin
            n_fail++;
            $display("FAIL short_rearm: got writes=%0d dones=%0d expected writes=%0d dones=1", writes, dones, N);
        end
    endtask

    task automatic test_short_frame;
        int writes = 0, dones = 0;
        logic [23:0] e;
        exp_q.delete();
        for (int i = 0; i < (CUT_LINE - Y0 + 1) * W; i++) exp_q.push_back({16'(i), 8'(X0 + i % W)});
        arm = 1'b1;
        tick;
        arm = 1'b0;
        repeat (3 * FRAME) begin
            tick;
            if (wrEnable) begin
                writes++;
                if (writes == 1) cut_req++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL cut_extra: got write addr=%0d expected none", wrAddress);
                end else begin
                    e = exp_q.pop_front();
                    if ({wrAddress, wrData} !== e) begin
                        n_fail++;
                        $display("FAIL cut_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 wrAddress, wrData, e[23:8], e[7:0]);
                    end
                end
            end
            if (frameDone) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL cut_done: got %0d expected 0", dones); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL cut_missing: got %0d left expected 0", exp_q.size()); end
        n_checks++;
        if ({busy, syncError} !== 2'b01) begin
            n_fail++;
            $display("FAIL cut_state: got busy=%b err=%b expected busy=0 err=1", busy, syncError);
        end
    endtask

    task automatic test_reset_mid;
        int writes = 0, stray = 0;
        logic hit = 1'b0;
        logic [23:0] e;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({16'(i), 8'(X0 + i % W)});
        arm = 1'b1;
        tick;
        arm = 1'b0;
        for (int t = 0; t < 3 * FRAME && !hit; t++) begin
            tick;
            if (wrEnable) begin
                writes++;
                e = exp_q.pop_front();
                n_checks++;
                if ({wrAddress, wrData} !== e) begin
                    n_fail++;
                    $display("FAIL rst_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             wrAddress, wrData, e[23:8], e[7:0]);
                end
                if (writes == 200) begin
                    rst_n = 1'b0;
                    #1;
                    hit = 1'b1;
                    n_checks++;
                    if ({wrAddress, wrData, wrEnable, busy, frameDone, syncError} !== 28'd0) begin
                        n_fail++;
                        $display("FAIL rst_async: got addr=%0d data=%0d we=%b busy=%b done=%b err=%b, expected all 0",
                                 wrAddress, wrData, wrEnable, busy, frameDone, syncError);
                    end
                end
            end
        end
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach: got %0d writes expected 200", writes); end
        repeat (3) tick;
        for (int t = 0; t < 2 * FRAME && !(hc == HS + 2 && vc >= 2); t++) tick;
        rst_n = 1'b1;
        repeat (2 * FRAME) begin
            tick;
            if (wrEnable || busy) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL rst_after: got %0d active cycles expected 0", stray); end
    endtask

    task automatic test_coincident;
        int writes = 0, dones = 0;
        logic [23:0] e;
        pix_line = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({16'(i), 8'(Y0 + i / W)});
        arm = 1'b1;
        tick;
        arm = 1'b0;
        repeat (2 * FRAME + 4 * HT) begin
            tick;
            if (wrEnable) begin
                writes++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL coin_extra: got write addr=%0d expected none", wrAddress);
                end else begin
                    e = exp_q.pop_front();
                    if ({wrAddress, wrData} !== e) begin
                        n_fail++;
                        $display("FAIL coin_write: got addr=%0d line=%0d expected addr=%0d line=%0d",
                                 wrAddress, wrData, e[23:8], e[7:0]);
                    end
                end
            end
            if (frameDone) dones++;
        end
        pix_line = 1'b0;
        n_checks++;
        if ({writes, dones} !== {N, 32'd1}) begin
            n_fail++;
            $display("FAIL coin_count: got writes=%0d dones=%0d expected writes=%0d dones=1", writes, dones, N);
        end
        n_checks++;
        if (syncError !== 1'b0) begin n_fail++; $display("FAIL coin_sync: got %b expected 0", syncError); end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_short_line;
        test_short_frame;
        test_reset_mid;
        test_coincident;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
